// File: rtl/button_event.sv
// Button event decoder: press/release edges, short/long press classification and auto-repeat
// with a saturating repeat counter, all from one debounced, clk-synchronous button level.
module button_event #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned LONG_MS    = 1000,
    parameter int unsigned REPEAT_MS  = 200,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] repeat_count
);

    // 64-bit intermediates: the default CLK_FREQ * LONG_MS overflows 32 bits.
    localparam longint unsigned LONG_CYC_W =
        64'(CLK_FREQ) * 64'(LONG_MS) / 64'd1000;
    localparam longint unsigned REPEAT_CYC_W =
        64'(CLK_FREQ) * 64'(REPEAT_MS) / 64'd1000;

    localparam int unsigned LONG_CYC   = 32'(LONG_CYC_W);
    localparam int unsigned REPEAT_CYC = 32'(REPEAT_CYC_W);
    localparam int unsigned MAX_CYC    = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int unsigned CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

    if (LONG_CYC_W < 64'd2) begin : g_bad_long
        $fatal(1, "button_event: LONG_CYC must be at least 2");
    end
    if (REPEAT_CYC_W < 64'd1) begin : g_bad_repeat
        $fatal(1, "button_event: REPEAT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StPress,
        StLong
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_lvl;

    assign w_lvl = btn ^ ACTIVE_LOW;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            repeat_count  <= 8'd0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (w_lvl) begin
                        r_state      <= StPress;
                        r_cnt        <= '0;
                        repeat_count <= 8'd0;
                        press_pulse  <= 1'b1;
                        held         <= 1'b1;
                    end
                end
                StPress: begin
                    // Release is checked first so it wins over a threshold hit.
                    if (!w_lvl) begin
                        r_state       <= StIdle;
                        r_cnt         <= '0;
                        release_pulse <= 1'b1;
                        short_press   <= 1'b1;
                        held          <= 1'b0;
                    end else if (r_cnt == LONG_LAST) begin
                        r_state    <= StLong;
                        r_cnt      <= '0;
                        long_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StLong: begin
                    if (!w_lvl) begin
                        r_state       <= StIdle;
                        r_cnt         <= '0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (r_cnt == REPEAT_LAST) begin
                        r_cnt        <= '0;
                        repeat_pulse <= 1'b1;
                        if (repeat_count != 8'hFF) begin
                            repeat_count <= repeat_count + 8'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                    held    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Randomized scoreboard bench for button_event: an event-list model of each press is queued
// up front and a negedge monitor pops and compares whenever the DUT raises any pulse.
module tb_button_event;

    localparam int unsigned CLK_FREQ  = 1000;
    localparam int unsigned LONG_MS   = 10;
    localparam int unsigned REPEAT_MS = 4;
    localparam int LONG_CYC   = 10;
    localparam int REPEAT_CYC = 4;

    localparam logic [4:0] P_PRESS = 5'b10000;
    localparam logic [4:0] P_REL   = 5'b01000;
    localparam logic [4:0] P_SHORT = 5'b00100;
    localparam logic [4:0] P_LONG  = 5'b00010;
    localparam logic [4:0] P_REP   = 5'b00001;

    typedef struct {
        int         cyc;
        logic [4:0] pulses;
        logic       held;
        logic [7:0] rcount;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       btn0;
    logic       btn1;
    logic       press0, rel0, short0, long0, rep0, held0;
    logic [7:0] rc0;
    logic       press1, rel1, short1, long1, rep1, held1;
    logic [7:0] rc1;

    int  cyc;
    int  n_checks;
    int  n_pass;
    ev_t q0[$];
    ev_t q1[$];

    button_event #(
        .CLK_FREQ  (CLK_FREQ),
        .LONG_MS   (LONG_MS),
        .REPEAT_MS (REPEAT_MS),
        .ACTIVE_LOW(1'b1)
    ) dut0 (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn0),
        .press_pulse  (press0),
        .release_pulse(rel0),
        .short_press  (short0),
        .long_press   (long0),
        .repeat_pulse (rep0),
        .held         (held0),
        .repeat_count (rc0)
    );

    button_event #(
        .CLK_FREQ  (CLK_FREQ),
        .LONG_MS   (LONG_MS),
        .REPEAT_MS (REPEAT_MS),
        .ACTIVE_LOW(1'b0)
    ) dut1 (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn1),
        .press_pulse  (press1),
        .release_pulse(rel1),
        .short_press  (short1),
        .long_press   (long1),
        .repeat_pulse (rep1),
        .held         (held1),
        .repeat_count (rc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    function automatic void add_ev(input int inst, input int c, input logic [4:0] p,
                                   input logic h, input int rc);
        ev_t e;
        e.cyc    = c;
        e.pulses = p;
        e.held   = h;
        e.rcount = 8'((rc > 255) ? 255 : rc);
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endfunction

    // Press whose first pressed sample is the edge after cycle c, held for d samples.
    function automatic void push_events(input int inst, input int c, input int d);
        int nrep;
        nrep = 0;
        add_ev(inst, c + 1, P_PRESS, 1'b1, 0);
        if (d > LONG_CYC) add_ev(inst, c + 1 + LONG_CYC, P_LONG, 1'b1, 0);
        for (int j = LONG_CYC + REPEAT_CYC; j < d; j += REPEAT_CYC) begin
            nrep++;
            add_ev(inst, c + 1 + j, P_REP, 1'b1, nrep);
        end
        if (d > LONG_CYC) add_ev(inst, c + 1 + d, P_REL, 1'b0, nrep);
        else              add_ev(inst, c + 1 + d, P_REL | P_SHORT, 1'b0, nrep);
    endfunction

    task automatic compare_ev(input int inst, input logic [4:0] p, input logic h,
                              input logic [7:0] rc);
        ev_t e;
        n_checks++;
        if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
            $display("FAIL unexpected_event dut%0d cyc=%0d: got pulses=%b held=%b rc=%0d, required none",
                     inst, cyc, p, h, rc);
            return;
        end
        if (inst == 0) e = q0.pop_front();
        else           e = q1.pop_front();
        if (e.cyc != cyc || e.pulses != p || e.held != h || e.rcount != rc) begin
            $display("FAIL event dut%0d: got cyc=%0d pulses=%b held=%b rc=%0d, required cyc=%0d pulses=%b held=%b rc=%0d",
                     inst, cyc, p, h, rc, e.cyc, e.pulses, e.held, e.rcount);
        end else begin
            n_pass++;
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset) begin
                if ({press0, rel0, short0, long0, rep0} != 5'b0)
                    compare_ev(0, {press0, rel0, short0, long0, rep0}, held0, rc0);
                if ({press1, rel1, short1, long1, rep1} != 5'b0)
                    compare_ev(1, {press1, rel1, short1, long1, rep1}, held1, rc1);
            end
        end
    endtask

    task automatic check_zero(input string name);
        logic [13:0] got0;
        logic [13:0] got1;
        got0 = {press0, rel0, short0, long0, rep0, held0, rc0};
        got1 = {press1, rel1, short1, long1, rep1, held1, rc1};
        n_checks++;
        if (got0 != 14'd0) $display("FAIL %s dut0: got %b, required all zero", name, got0);
        else               n_pass++;
        n_checks++;
        if (got1 != 14'd0) $display("FAIL %s dut1: got %b, required all zero", name, got1);
        else               n_pass++;
    endtask

    task automatic press0_for(input int d, input int gap);
        @(negedge clk);
        push_events(0, cyc, d);
        btn0 = 1'b0;
        repeat (d) @(negedge clk);
        btn0 = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int c;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        btn0     = 1'b1;
        btn1     = 1'b0;
        #1;
        check_zero("reset_state");
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        press0_for(5, 3);
        press0_for(25, 3);
        press0_for(10, 3);
        press0_for(11, 3);
        press0_for(1, 3);
        for (int i = 0; i < 14; i++) begin
            press0_for(int'($urandom_range(40, 1)), int'($urandom_range(5, 1)));
        end
        press0_for(LONG_CYC + REPEAT_CYC * 300, 3);
        press0_for(2, 3);

        // Active-high instance: btn1 idles at 0 for the whole run otherwise.
        @(negedge clk);
        push_events(1, cyc, 3);
        btn1 = 1'b1;
        repeat (3) @(negedge clk);
        btn1 = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during LONG after one repeat, button kept pressed through reset.
        @(negedge clk);
        c = cyc;
        add_ev(0, c + 1, P_PRESS, 1'b1, 0);
        add_ev(0, c + 1 + LONG_CYC, P_LONG, 1'b1, 0);
        add_ev(0, c + 1 + LONG_CYC + REPEAT_CYC, P_REP, 1'b1, 1);
        btn0 = 1'b0;
        repeat (LONG_CYC + REPEAT_CYC + 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_zero("reset_mid_long");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_events(0, cyc, 3);
        repeat (3) @(negedge clk);
        btn0 = 1'b1;
        repeat (6) @(negedge clk);

        n_checks++;
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL missing_events: got %0d/%0d events still queued, required 0/0",
                     q0.size(), q1.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter LONG_MS, default 1000, hold time in ms before a press counts as long.
REQ-003 SHALL have parameter REPEAT_MS, default 200, auto-repeat period in ms after a long press.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; 1 means btn = 0 is pressed (DE10-Lite KEY).
REQ-005 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port btn, input, 1 bit: debounced button level, already synchronous to clk.
REQ-008 SHALL have port press_pulse, output, 1 bit: one-cycle pulse on press.
REQ-009 SHALL have port release_pulse, output, 1 bit: one-cycle pulse on release.
REQ-010 SHALL have port short_press, output, 1 bit: one-cycle pulse on release before the long threshold.
REQ-011 SHALL have port long_press, output, 1 bit: one-cycle pulse when the hold reaches LONG_CYC.
REQ-012 SHALL have port repeat_pulse, output, 1 bit: one-cycle pulse every REPEAT_CYC while held after long_press.
REQ-013 SHALL have port held, output, 1 bit: high while the FSM is not in IDLE.
REQ-014 SHALL have port repeat_count, output, 8 bits: repeat_pulse count since the last press, saturating.

Function
REQ-015 SHALL compute LONG_CYC = CLK_FREQ*LONG_MS/1000 and REPEAT_CYC = CLK_FREQ*REPEAT_MS/1000 in integer arithmetic; elaboration SHALL fail if LONG_CYC < 2 or REPEAT_CYC < 1.
REQ-016 SHALL derive the internal level lvl = btn XOR ACTIVE_LOW, so lvl = 1 means pressed.
REQ-017 SHALL size one internal cycle counter to hold max(LONG_CYC, REPEAT_CYC) - 1 without overflow.
REQ-018 SHALL use an FSM with exactly three states: IDLE, PRESS and LONG.
REQ-019 SHALL register all outputs; every pulse output SHALL be high for exactly one cycle per event.
REQ-020 IDLE with lvl = 1 sampled: SHALL go to PRESS, clear the counter and repeat_count, and assert press_pulse in the following cycle.
REQ-021 PRESS with lvl = 1: SHALL increment the counter; when the counter equals LONG_CYC-1, it SHALL clear the counter, go to LONG, and assert long_press, exactly LONG_CYC cycles after press_pulse.
REQ-022 PRESS with lvl = 0: SHALL go to IDLE and assert release_pulse and short_press in the same cycle.
REQ-023 LONG with lvl = 1: SHALL increment the counter; at REPEAT_CYC-1 it SHALL clear the counter, assert repeat_pulse, and increment repeat_count, saturating at 255.
REQ-024 The first repeat_pulse SHALL come REPEAT_CYC cycles after long_press; later ones SHALL follow every REPEAT_CYC cycles.
REQ-025 LONG with lvl = 0: SHALL go to IDLE and assert release_pulse only, with no short_press; repeat_count SHALL hold its value until the next press.
REQ-026 Release sampled in the same cycle the counter reaches a threshold: release SHALL win, with no long_press or repeat_pulse and the release outputs per REQ-022/REQ-025.
REQ-027 A 1-cycle press (lvl high for one sample) SHALL yield press_pulse, then release_pulse and short_press one cycle later.
REQ-028 btn held pressed through reset deassertion SHALL produce a press_pulse on the first sampled cycle after reset.
REQ-029 press_pulse and release_pulse SHALL never be high in the same cycle.

Reset
REQ-030 reset high SHALL immediately force state IDLE, the counter to 0, repeat_count to 0, and every 1-bit output to 0, regardless of clk.
REQ-031 Reset asserted mid-PRESS or mid-LONG SHALL discard the event and generate no release or short pulse.

Verification
(Bench parameters: CLK_FREQ=1000, LONG_MS=10, REPEAT_MS=4, ACTIVE_LOW=1, giving LONG_CYC=10 and REPEAT_CYC=4.)
REQ-032 Short press: btn=0 for 5 cycles, then 1 -> press_pulse once, then release_pulse and short_press together 5 cycles later; no long_press.
REQ-033 Long hold: btn=0 for 25 cycles -> long_press 10 cycles after press_pulse; repeat_pulse at +14, +18, +22 and +26 only if still held (here +14, +18, +22); repeat_count=3; on release, release_pulse without short_press.
REQ-034 Boundary: btn=0 for exactly 10 cycles -> long_press is absent if release is sampled on the threshold cycle; for 11 cycles -> long_press once, then release_pulse.
REQ-035 Saturation: hold for 10+4*300 cycles -> repeat_count stops at 255 while repeat_pulse continues; a new press clears repeat_count to 0.
REQ-036 Reset mid-LONG: assert reset for 2 cycles during a hold -> all outputs 0 at once; with btn still 0 after release of reset, press_pulse on the next sampled cycle.
REQ-037 Polarity: ACTIVE_LOW=0, btn=1 for 3 cycles -> press_pulse, then short_press and release_pulse; btn idle at 0 -> no events.
